// File: rtl/uart_hex_dumper_pkg.sv
// Shared definitions for the hex dumper: formatter states, ASCII constants
// and the nibble-to-character encoder.
package uart_hex_dumper_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_HI    = 4'd1,
      ST_HI_W  = 4'd2,
      ST_LO    = 4'd3,
      ST_LO_W  = 4'd4,
      ST_SEP   = 4'd5,
      ST_SEP_W = 4'd6,
      ST_LF    = 4'd7,
      ST_LF_W  = 4'd8
   } dump_state_e;

   localparam logic [7:0] ASCII_SP = 8'h20;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return ASCII_0 + {4'd0, nib};
      end
      return ASCII_A + {4'd0, nib} - 8'd10;
   endfunction

endpackage

// File: rtl/uart_hex_dumper_byte_fifo.sv
// Synchronous FIFO with a registered read port; dout updates only on a
// successful pop and then holds, so the consumer can use it as its hold register.
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = dout_q;

   // Storage and read register carry no reset so they map onto block RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
      if (do_pop) begin
         dout_q <= mem_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_hex_dumper.sv
// Turns a byte stream into "HH " / "HH\r\n" ASCII text, one character at a
// time into uart_tx, back-pressuring the source through a small FIFO.
module uart_hex_dumper
   import uart_hex_dumper_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       in_ready,
   output logic       uart_dv,
   output logic [7:0] uart_cout,
   input  logic       uart_busy,
   input  logic       uart_done,
   output logic       overrun
);
   dump_state_e state_q, state_d;
   logic [7:0]  cout_q, cout_d;
   logic        overrun_q;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [8:0]  held_q;

   byte_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
      .clk     (CLK),
      .reset_n (reset_n),
      .push    (in_valid),
      .pop     (fifo_pop),
      .din     ({in_last, in_data}),
      .dout    (held_q),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign in_ready  = !fifo_full;
   assign overrun   = overrun_q;
   assign uart_cout = cout_d;

   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cout_q    <= 8'h00;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cout_q    <= cout_d;
         overrun_q <= overrun_q || (in_valid && !in_ready);
      end
   end

   always_comb begin
      state_d  = state_q;
      cout_d   = cout_q;
      uart_dv  = 1'b0;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Waiting for uart_busy to clear avoids colliding with a character
            // still in flight from before a reset.
            if (!fifo_empty && !uart_busy) begin
               fifo_pop = 1'b1;
               state_d  = ST_HI;
            end
         end
         ST_HI: begin
            uart_dv = 1'b1;
            cout_d  = hex_char(held_q[7:4]);
            state_d = ST_HI_W;
         end
         ST_HI_W:  if (uart_done) state_d = ST_LO;
         ST_LO: begin
            uart_dv = 1'b1;
            cout_d  = hex_char(held_q[3:0]);
            state_d = ST_LO_W;
         end
         ST_LO_W:  if (uart_done) state_d = ST_SEP;
         ST_SEP: begin
            uart_dv = 1'b1;
            cout_d  = held_q[8] ? ASCII_CR : ASCII_SP;
            state_d = ST_SEP_W;
         end
         ST_SEP_W: if (uart_done) state_d = held_q[8] ? ST_LF : ST_IDLE;
         ST_LF: begin
            uart_dv = 1'b1;
            cout_d  = ASCII_LF;
            state_d = ST_LF_W;
         end
         ST_LF_W:  if (uart_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_hex_dumper.sv
// Scoreboard bench for uart_hex_dumper with a behavioural uart_tx model.
module tb_uart_hex_dumper;
   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic       uart_dv;
   logic [7:0] uart_cout;
   logic       uart_busy;
   logic       uart_done = 1'b0;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int dv_count = 0;
   int accepted = 0;
   logic [7:0] exp_q[$];
   bit prev_dv = 1'b0;
   bit active = 1'b0;
   bit stall = 1'b0;
   bit rand_delay = 1'b0;
   int cnt = 0;

   assign uart_busy = active | stall;

   uart_hex_dumper #(.DEPTH(16)) dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .uart_dv   (uart_dv),
      .uart_cout (uart_cout),
      .uart_busy (uart_busy),
      .uart_done (uart_done),
      .overrun   (overrun)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'd48 + 8'(n)) : (8'd55 + 8'(n));
   endfunction

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   // Input capture, output scoreboard and uart_tx model, in a fixed order.
   always @(negedge CLK) begin
      uart_done = 1'b0;
      if (reset_n && in_valid && in_ready) begin
         exp_q.push_back(hexc(in_data[7:4]));
         exp_q.push_back(hexc(in_data[3:0]));
         exp_q.push_back(in_last ? 8'h0D : 8'h20);
         if (in_last) exp_q.push_back(8'h0A);
         accepted++;
         $display("accept byte 0x%02h last=%0d", in_data, in_last);
      end
      if (reset_n && uart_dv) begin
         dv_count++;
         check("dv_single_cycle", int'(prev_dv), 0);
         check("dv_while_uart_active", int'(active), 0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char: got 0x%02h required none", uart_cout);
         end else begin
            check("char", int'(uart_cout), int'(exp_q.pop_front()));
         end
      end
      prev_dv = uart_dv;
      if (uart_dv) begin
         active = 1'b1;
         cnt = rand_delay ? int'($urandom_range(2, 30)) : 19;
      end else if (active && !stall) begin
         if (cnt == 0) begin
            uart_done = 1'b1;
            active = 1'b0;
         end else begin
            cnt--;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data = d;
      in_last = last;
      @(negedge CLK);
      while (!in_ready && n < 50000) begin
         @(negedge CLK);
         n++;
      end
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      check("send_timeout", int'(n < 50000), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || uart_busy) && n < 20000) begin
         @(posedge CLK);
         n++;
      end
      repeat (5) @(posedge CLK);
      #1;
      check("drain_complete", int'(n < 20000), 1);
   endtask

   initial begin
      int dv0, acc0, n;
      bit seen_low, ovr_checked, prev_ready;

      repeat (3) @(posedge CLK);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_uart_dv", int'(uart_dv), 0);
      check("rst_uart_cout", int'(uart_cout), 0);
      check("rst_overrun", int'(overrun), 0);
      reset_n = 1'b1;
      @(posedge CLK);
      #1;

      dv0 = dv_count;
      send(8'h3A, 1'b1);
      drain();
      check("single_byte_dv_pulses", dv_count - dv0, 4);

      dv0 = dv_count;
      send(8'h00, 1'b0);
      send(8'hFF, 1'b1);
      drain();
      check("two_byte_dv_pulses", dv_count - dv0, 7);

      in_valid = 1'b1;
      in_data = 8'h5C;
      in_last = 1'b0;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(negedge CLK);
      check("latency_n1_dv", int'(uart_dv), 0);
      @(negedge CLK);
      check("latency_n2_dv", int'(uart_dv), 1);
      check("latency_n2_cout", int'(uart_cout), 8'h35);
      drain();

      stall = 1'b1;
      @(posedge CLK);
      #1;
      acc0 = accepted;
      seen_low = 1'b0;
      ovr_checked = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'($urandom);
         in_last = ($urandom_range(0, 3) == 0);
         @(negedge CLK);
         if (!in_ready) begin
            if (!seen_low) begin
               check("bp_accepts_before_full", accepted - acc0, 16);
               check("bp_overrun_before", int'(overrun), 0);
               seen_low = 1'b1;
            end else if (!ovr_checked) begin
               check("bp_overrun_set", int'(overrun), 1);
               ovr_checked = 1'b1;
            end
         end
         @(posedge CLK);
         #1;
      end
      check("bp_ready_dropped", int'(seen_low), 1);
      check("bp_total_accepted", accepted - acc0, 16);

      in_data = 8'($urandom);
      in_last = 1'b1;
      stall = 1'b0;
      n = 0;
      prev_ready = 1'b1;
      @(negedge CLK);
      while (!uart_dv && n < 10) begin
         prev_ready = in_ready;
         @(negedge CLK);
         n++;
      end
      check("pop_dv_seen", int'(uart_dv), 1);
      check("pop_ready_before", int'(prev_ready), 0);
      check("pop_ready_after", int'(in_ready), 1);
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      @(negedge CLK);
      check("refill_full", int'(in_ready), 0);
      drain();
      check("overrun_sticky", int'(overrun), 1);

      rand_delay = 1'b1;
      for (int i = 0; i < 40; i++) begin
         send(8'($urandom), ($urandom_range(0, 4) == 0));
         repeat ($urandom_range(0, 3)) @(posedge CLK);
         #1;
      end
      drain();
      rand_delay = 1'b0;

      dv0 = dv_count;
      send(8'hA7, 1'b1);
      n = 0;
      while (dv_count < dv0 + 2 && n < 2000) begin
         @(posedge CLK);
         n++;
      end
      check("rst_reached_lo", int'(n < 2000), 1);
      repeat (3) @(posedge CLK);
      #1;
      check("rst_uart_busy_before", int'(uart_busy), 1);
      reset_n = 1'b0;
      @(posedge CLK);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      check("rst_mid_in_ready", int'(in_ready), 1);
      check("rst_mid_dv", int'(uart_dv), 0);
      check("rst_mid_overrun", int'(overrun), 0);
      dv0 = dv_count;
      n = 0;
      while (uart_busy && n < 2000) begin
         @(posedge CLK);
         n++;
      end
      repeat (10) @(posedge CLK);
      #1;
      check("rst_no_dv_until_push", dv_count - dv0, 0);
      send(8'hC4, 1'b0);
      drain();
      check("rst_after_push_dv", dv_count - dv0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
